de_sched14: RTL and testbench
=============================

Name: de_sched14

Overview:
- Scheduler and sequencer for a 1-to-4 data distributor with idle-high outputs. Unselected outputs sit at 1; the selected output carries data.
- Accepts a bit-serial source stream with a valid/ready handshake.
- Grants the stream to one of four channels in round-robin order, in fixed-length bursts.
- Drives the select lines and the four registered channel outputs.
- Sits between a serial source and four downstream channel consumers.

Parameters:
- BURST, 4, bits delivered per grant (legal range 2..256); counter width is clog2(BURST).

Ports:
- iClk input 1: system clock. All logic is on the rising edge.
- iRst input 1: reset, synchronous and active-high.
- iData input 1: serial data bit from the source.
- iValid input 1: iData is valid this cycle.
- oReady output 1: the scheduler accepts iData this cycle. A transfer occurs when iValid and oReady are both 1.
- iEn input 4: per-channel enable mask. Bit k enables channel k.
- iChRdy input 4: per-channel consumer ready.
- oS1 output 1: select MSB of the granted channel.
- oS0 output 1: select LSB of the granted channel.
- oZ0 output 1: channel 0 output, registered, idle 1.
- oZ1 output 1: channel 1 output, registered, idle 1.
- oZ2 output 1: channel 2 output, registered, idle 1.
- oZ3 output 1: channel 3 output, registered, idle 1.
- oBusy output 1: high from GRANT through GAP inclusive.
- oAbort output 1: one-cycle pulse when a burst is aborted.

Behaviour:
- Reset values:
  - oZ0..oZ3 = 1; oS1/oS0 = 0; oReady = 0; oBusy = 0; oAbort = 0.
  - State = IDLE; burst counter = 0; last-served pointer = 3, so channel 0 is served first.
  - Reset asserted mid-burst abandons the burst immediately. No oAbort pulse is produced.
- Eligibility: channel k is eligible when iEn[k] & iChRdy[k].
- IDLE:
  - oReady = 0.
  - If iValid = 1 and any channel is eligible, pick the first eligible channel searching last+1, last+2, ... (mod 4), latch it as sel, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT (1 cycle): {oS1, oS0} = sel; oReady = 0; go to SEND.
- SEND:
  - {oS1, oS0} holds sel.
  - oReady = iChRdy[sel] & iEn[sel].
  - On each transfer, the bit is registered to oZ[sel] for the next cycle and the counter increments.
  - If the transfer occurs with counter = BURST-1: counter clears, go to GAP.
  - Cycles with no transfer (iValid low, or iChRdy[sel] low) are a stall. oZ[sel] returns to 1 the cycle after a stall and the counter holds.
  - If iEn[sel] = 0 while in SEND: oAbort pulses for 1 cycle, counter clears, last = sel, go to IDLE. Bits already transferred are not retracted.
  - iEn[sel] clearing has priority over a simultaneous final transfer (the transfer is not accepted, because oReady = 0).
- GAP (1 cycle):
  - The last bit appears on oZ[sel]; {oS1, oS0} still holds sel; oReady = 0.
  - last = sel; go to IDLE.
- Latency:
  - Accepted bit to channel output: 1 cycle.
  - iValid rising with an eligible channel to first oReady: 2 cycles (IDLE to GRANT to SEND).
  - Minimum cycles per burst: BURST + 3.
- Outputs:
  - Only oZ[sel] may be 0; all other oZ are 1 in every cycle.
  - oS1/oS0 keep their last value in IDLE.
- iEn/iChRdy changes for non-selected channels have no effect until the next arbitration.

Optional Feature:
- Macro: DE_SCHED14_FIXED_PRIO_EN.
- Defined: arbitration in IDLE is fixed priority, with channel 0 highest and channel 3 lowest. The last-served pointer is unused.
- Undefined (default): round-robin as above.
- All other behaviour is identical.

Test Plan:
- Reset, then iEn=4'b1111, iChRdy=4'b1111, iValid=1, iData=1,0,1,1,... with BURST=4 -> grants go to ch0, ch1, ch2, ch3, ch0. oZk shows 1,0,1,1 one cycle after each accept. Every other oZ stays 1. Each burst spans 7 cycles.
- iEn=4'b1010 with continuous valid -> grants alternate ch1, ch3. {oS1, oS0} alternates 01 and 11. oZ0 and oZ2 are never 0.
- Mid-burst on ch2, drop iChRdy[2] for 3 cycles -> oReady=0 for exactly 3 cycles, oZ2=1 during the stall, and the burst completes with 4 bits total. oAbort stays 0.
- Mid-burst on ch1 after 2 bits, clear iEn[1] -> oAbort=1 for one cycle, return to IDLE. The next grant goes to ch2, not ch1.
- Assert iRst during SEND -> next cycle oZ0..oZ3=1, oReady=0, oBusy=0, oAbort=0. After release, the first grant goes to ch0.
- With DE_SCHED14_FIXED_PRIO_EN defined, iEn=4'b1111 -> every grant goes to ch0. With iEn=4'b1110 -> every grant goes to ch1.

Source files
------------

// File: rtl/de_sched14.sv
// rtl/de_sched14.sv - round-robin burst scheduler for a 1-to-4 idle-high serial distributor
// Optional build macro: DE_SCHED14_FIXED_PRIO_EN selects fixed-priority arbitration (ch0 highest).
module de_sched14 #(
  parameter int BURST = 4
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iData,
  input  logic       iValid,
  output logic       oReady,
  input  logic [3:0] iEn,
  input  logic [3:0] iChRdy,
  output logic       oS1,
  output logic       oS0,
  output logic       oZ0,
  output logic       oZ1,
  output logic       oZ2,
  output logic       oZ3,
  output logic       oBusy,
  output logic       oAbort
);

  localparam int CW = $clog2(BURST);

  typedef enum logic [1:0] {IDLE, GRANT, SEND, GAP} state_t;

  state_t          state, stateNxt;
  logic [1:0]      sel, selNxt;
  logic [1:0]      last, lastNxt;
  logic [CW-1:0]   cnt, cntNxt;
  logic [3:0]      z, zNxt;
  logic            abortQ, abortNxt;
  logic [3:0]      elig;
  logic [1:0]      pick;
  logic [1:0]      cand;
  logic            found;

  assign elig = iEn & iChRdy;

  // Arbitration: choose the next channel to grant among the eligible ones
  always_comb begin
    pick  = 2'd0;
    cand  = 2'd0;
    found = 1'b0;
`ifdef DE_SCHED14_FIXED_PRIO_EN
    // Descending scan so the lowest-numbered eligible channel is the final winner
    for (int i = 3; i >= 0; i--) begin
      if (elig[i]) begin
        pick  = 2'(i);
        found = 1'b1;
      end
    end
`else
    // Offsets 0,3,2,1 from last are scanned so offset 1 (last+1) wins when eligible
    for (int i = 4; i >= 1; i--) begin
      cand = last + 2'(i);
      if (elig[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
`endif
  end

  // Next-state, handshake and channel-output data path
  always_comb begin
    stateNxt = state;
    selNxt   = sel;
    lastNxt  = last;
    cntNxt   = cnt;
    zNxt     = 4'hF;
    abortNxt = 1'b0;
    oReady   = 1'b0;
    case (state)
      IDLE: begin
        if (iValid && found) begin
          selNxt   = pick;
          stateNxt = GRANT;
        end
      end
      GRANT: stateNxt = SEND;
      SEND: begin
        // Losing the enable beats any same-cycle transfer: ready is withheld
        if (!iEn[sel]) begin
          abortNxt = 1'b1;
          cntNxt   = '0;
          lastNxt  = sel;
          stateNxt = IDLE;
        end else begin
          oReady = iChRdy[sel];
          if (iValid && iChRdy[sel]) begin
            zNxt[sel] = iData;
            if (cnt == CW'(BURST - 1)) begin
              cntNxt   = '0;
              stateNxt = GAP;
            end else begin
              cntNxt = cnt + 1'b1;
            end
          end
        end
      end
      GAP: begin
        lastNxt  = sel;
        stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  // State and registered outputs; reset drops any burst in progress silently
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state  <= IDLE;
      sel    <= 2'd0;
      last   <= 2'd3;
      cnt    <= '0;
      z      <= 4'hF;
      abortQ <= 1'b0;
    end else begin
      state  <= stateNxt;
      sel    <= selNxt;
      last   <= lastNxt;
      cnt    <= cntNxt;
      z      <= zNxt;
      abortQ <= abortNxt;
    end
  end

  assign {oS1, oS0} = sel;
  assign {oZ3, oZ2, oZ1, oZ0} = z;
  assign oBusy  = (state != IDLE);
  assign oAbort = abortQ;

endmodule

// File: tb/tb_de_sched14.sv
// tb/tb_de_sched14.sv - scoreboard bench for de_sched14
module tb_de_sched14;
  localparam int BURST = 4;

  logic       iClk = 1'b0;
  logic       iRst, iData, iValid;
  logic [3:0] iEn, iChRdy;
  logic       oReady, oS1, oS0, oZ0, oZ1, oZ2, oZ3, oBusy, oAbort;

  de_sched14 #(.BURST(BURST)) dut (
    .iClk(iClk), .iRst(iRst), .iData(iData), .iValid(iValid), .oReady(oReady),
    .iEn(iEn), .iChRdy(iChRdy), .oS1(oS1), .oS0(oS0),
    .oZ0(oZ0), .oZ1(oZ1), .oZ2(oZ2), .oZ3(oZ3), .oBusy(oBusy), .oAbort(oAbort)
  );

  always #5 iClk = ~iClk;

  typedef struct packed {
    logic [1:0] ch;
    logic       b;
  } exp_t;

  exp_t       expQ[$];
  logic [1:0] grantQ[$];
  int   total = 0;
  int   bad = 0;
  int   bitsInGrant = 0;
  int   cyc = 0;
  int   abortCnt = 0;
  int   prevFirst = -1;
  int   patIdx = 0;
  bit   pend = 0;
  bit   monOn = 0;
  bit   hsSeen = 0;
  bit   checkSpan = 0;
  logic pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  exp_t monE;
  logic [1:0] monCh;

  function automatic logic [3:0] vecFor(exp_t e);
    logic [3:0] v;
    v = 4'hF;
    v[e.ch] = e.b;
    return v;
  endfunction

  // Monitor: compare registered channel outputs, then log any handshake into the scoreboard
  always @(negedge iClk) begin
    cyc++;
    if (monOn) begin
      if (oAbort) abortCnt++;
      total++;
      if (pend) begin
        if (expQ.size() == 0) begin
          bad++;
          $display("FAIL scoreboard_empty: output bit with no expected entry");
        end else begin
          monE = expQ.pop_front();
          if ({oZ3, oZ2, oZ1, oZ0} !== vecFor(monE)) begin
            bad++;
            $display("FAIL channel_out: got %b want %b", {oZ3, oZ2, oZ1, oZ0}, vecFor(monE));
          end
        end
      end else if ({oZ3, oZ2, oZ1, oZ0} !== 4'hF) begin
        bad++;
        $display("FAIL idle_out: got %b want 1111", {oZ3, oZ2, oZ1, oZ0});
      end
      pend = 0;
      if (iValid && oReady && !iRst) begin
        hsSeen = 1;
        if (grantQ.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_xfer: transfer accepted with sel=%0d, none expected", {oS1, oS0});
        end else begin
          monCh = grantQ[0];
          total++;
          if ({oS1, oS0} !== monCh) begin
            bad++;
            $display("FAIL select: got %0d want %0d", {oS1, oS0}, monCh);
          end
          if (bitsInGrant == 0) begin
            if (checkSpan && prevFirst >= 0) begin
              total++;
              if (cyc - prevFirst != BURST + 3) begin
                bad++;
                $display("FAIL burst_span: got %0d want %0d", cyc - prevFirst, BURST + 3);
              end
            end
            prevFirst = cyc;
          end
          monE.ch = monCh;
          monE.b  = iData;
          expQ.push_back(monE);
          pend = 1;
          bitsInGrant++;
          if (bitsInGrant == BURST) begin
            void'(grantQ.pop_front());
            bitsInGrant = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge iClk);
    #1;
    if (hsSeen) begin
      hsSeen = 0;
      patIdx++;
      iData = pat[patIdx % 4];
    end
  endtask

  task automatic runUntilDone(input int maxCyc);
    int n;
    n = 0;
    while (grantQ.size() != 0 && n < maxCyc) begin
      tick();
      n++;
    end
    total++;
    if (grantQ.size() != 0) begin
      bad++;
      $display("FAIL burst_timeout: grants left=%0d want 0", grantQ.size());
      grantQ.delete();
      bitsInGrant = 0;
    end
    iValid = 1'b0;
    repeat (4) tick();
  endtask

  task automatic waitBits(input int k);
    int n;
    n = 0;
    while (bitsInGrant < k && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (bitsInGrant < k) begin
      bad++;
      $display("FAIL bit_wait: got %0d bits want %0d", bitsInGrant, k);
    end
  endtask

  task automatic test_reset();
    iRst = 1'b1; iValid = 1'b0; iEn = 4'h0; iChRdy = 4'h0; iData = pat[0];
    tick();
    tick();
    @(negedge iClk);
    total += 5;
    if ({oZ3, oZ2, oZ1, oZ0} !== 4'hF) begin bad++; $display("FAIL reset_z: got %b want 1111", {oZ3, oZ2, oZ1, oZ0}); end
    if ({oS1, oS0} !== 2'b00) begin bad++; $display("FAIL reset_sel: got %b want 00", {oS1, oS0}); end
    if (oReady !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", oReady); end
    if (oBusy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", oBusy); end
    if (oAbort !== 1'b0) begin bad++; $display("FAIL reset_abort: got %b want 0", oAbort); end
    tick();
    iRst = 1'b0;
    monOn = 1;
  endtask

  task automatic test_round_robin();
    int a0;
    a0 = abortCnt;
    iEn = 4'hF; iChRdy = 4'hF;
    grantQ = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    checkSpan = 1; prevFirst = -1;
    iValid = 1'b1;
    tick();
    @(negedge iClk);
    total += 2;
    if (oReady !== 1'b0) begin bad++; $display("FAIL grant_ready: got %b want 0", oReady); end
    if (oBusy !== 1'b1) begin bad++; $display("FAIL grant_busy: got %b want 1", oBusy); end
    tick();
    @(negedge iClk);
    total++;
    if (oReady !== 1'b1) begin bad++; $display("FAIL first_ready: got %b want 1", oReady); end
    runUntilDone(60);
    checkSpan = 0;
    total++;
    if (abortCnt != a0) begin bad++; $display("FAIL rr_abort: got %0d pulses want 0", abortCnt - a0); end
  endtask

  task automatic test_mask();
    iEn = 4'b1010; iChRdy = 4'hF;
    grantQ = '{2'd1, 2'd3, 2'd1, 2'd3};
    iValid = 1'b1;
    runUntilDone(60);
  endtask

  task automatic test_stall();
    int a0;
    a0 = abortCnt;
    iEn = 4'b0100; iChRdy = 4'hF;
    grantQ = '{2'd2};
    iValid = 1'b1;
    waitBits(2);
    iChRdy = 4'b1011;
    repeat (3) begin
      @(negedge iClk);
      total++;
      if (oReady !== 1'b0) begin bad++; $display("FAIL stall_ready: got %b want 0", oReady); end
      tick();
    end
    iChRdy = 4'hF;
    @(negedge iClk);
    total++;
    if (oReady !== 1'b1) begin bad++; $display("FAIL stall_resume: got %b want 1", oReady); end
    runUntilDone(20);
    total += 2;
    if (oBusy !== 1'b0) begin bad++; $display("FAIL stall_done_busy: got %b want 0", oBusy); end
    if (abortCnt != a0) begin bad++; $display("FAIL stall_abort: got %0d pulses want 0", abortCnt - a0); end
  endtask

  task automatic test_abort();
    int a0;
    iEn = 4'b0010; iChRdy = 4'hF;
    grantQ = '{2'd1};
    iValid = 1'b1;
    waitBits(2);
    a0 = abortCnt;
    iEn = 4'b0000;
    @(negedge iClk);
    total++;
    if (oReady !== 1'b0) begin bad++; $display("FAIL abort_ready: got %b want 0", oReady); end
    repeat (4) tick();
    @(negedge iClk);
    total += 2;
    if (abortCnt - a0 != 1) begin bad++; $display("FAIL abort_pulse: got %0d pulses want 1", abortCnt - a0); end
    if (oBusy !== 1'b0) begin bad++; $display("FAIL abort_idle: got busy=%b want 0", oBusy); end
    grantQ.delete();
    bitsInGrant = 0;
    tick();
    iEn = 4'hF;
    grantQ = '{2'd2};
    runUntilDone(20);
  endtask

  task automatic test_reset_mid();
    int a0;
    iEn = 4'hF; iChRdy = 4'hF;
    grantQ = '{2'd3};
    iValid = 1'b1;
    waitBits(2);
    a0 = abortCnt;
    iRst = 1'b1;
    tick();
    @(negedge iClk);
    total += 4;
    if ({oZ3, oZ2, oZ1, oZ0} !== 4'hF) begin bad++; $display("FAIL midreset_z: got %b want 1111", {oZ3, oZ2, oZ1, oZ0}); end
    if (oReady !== 1'b0) begin bad++; $display("FAIL midreset_ready: got %b want 0", oReady); end
    if (oBusy !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b want 0", oBusy); end
    if (oAbort !== 1'b0) begin bad++; $display("FAIL midreset_abort: got %b want 0", oAbort); end
    grantQ.delete();
    bitsInGrant = 0;
    grantQ = '{2'd0};
    tick();
    iRst = 1'b0;
    runUntilDone(20);
    total++;
    if (abortCnt != a0) begin bad++; $display("FAIL midreset_pulses: got %0d want 0", abortCnt - a0); end
  endtask

  task automatic test_fixed_prio();
    iEn = 4'hF; iChRdy = 4'hF;
    grantQ = '{2'd0, 2'd0, 2'd0};
    iValid = 1'b1;
    runUntilDone(60);
    iEn = 4'b1110;
    grantQ = '{2'd1, 2'd1};
    iValid = 1'b1;
    runUntilDone(60);
  endtask

  initial begin
    test_reset();
`ifdef DE_SCHED14_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_round_robin();
    test_mask();
    test_stall();
    test_abort();
    test_reset_mid();
`endif
    total++;
    if (expQ.size() != 0) begin bad++; $display("FAIL leftover_expect: got %0d entries want 0", expQ.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
